usb_rx_sequencer: RTL
=====================

// Module: usb_rx_sequencer
// PURPOSE
//  Receive-side controller for the USB full-speed RX chain (NRZI decode -> bit unstuff).
//  - Watches the raw D+/D- line one symbol per clk.
//  - Finds SYNC and pulses start_rc_nrzi to launch the NRZI decoder FSM.
//  - Tracks the packet body; on a valid EOP pulses end_rc_nrzi.
//  - On any line/framing fault pulses abort, which the decoder and unstuffer use to clear.
// PARAMETERS
//  MAX_BITS  1100  max data-body symbols (post-SYNC, pre-EOP) before babble abort
//  CNT_W     11    width of bit_count; must satisfy 2**CNT_W > MAX_BITS
// PORTS
//  clk            in   1      system clock; one line symbol sampled per cycle
//  rst            in   1      reset; synchronous, active-high
//  dp             in   1      sampled D+ level
//  dm             in   1      sampled D- level
//  rx_en          in   1      receive enable; 0 = ignore line, abort active packet
//  rc_nrzi_wait   in   1      decoder idle/ready (1 = decoder in WAIT)
//  start_rc_nrzi  out  1      1-cycle pulse: first body symbol on line this cycle
//  end_rc_nrzi    out  1      1-cycle pulse: valid EOP completed
//  abort          out  1      1-cycle pulse: packet discarded; decoder/unstuffer clear
//  pkt_ok         out  1      1-cycle pulse coincident with end_rc_nrzi
//  err_code       out  3      last abort cause; held until next start_rc_nrzi
//  busy           out  1      1 in DATA/EOP1/EOP2
//  bit_count      out  CNT_W  body symbols counted in current/last packet
// BEHAVIOUR
//  Symbols: J={dp,dm}=10, K=01, SE0=00, SE1=11.
//  Reset: all outputs 0, err_code=000, state IDLE, sync shift reg and run counter cleared.
//  Timing: all outputs registered; every pulse asserts the cycle after the triggering sample.
//  FSM states: IDLE, DATA, EOP1, EOP2.
//  IDLE:
//   - 8-deep shift reg of J/K symbols; SE0/SE1 clears it.
//   - When it holds K J K J K J K K (oldest first), rx_en=1 and rc_nrzi_wait=1:
//     go DATA; start_rc_nrzi=1; bit_count<=0; run<=2; err_code<=000.
//   - SYNC match while rc_nrzi_wait=0 or rx_en=0: ignored; shift reg keeps shifting.
//  DATA, J/K symbol:
//   - bit_count++.
//   - run<=run+1 if same level as previous J/K symbol, else run<=1.
//  DATA, SE0: go EOP1; not counted.
//  EOP1: SE0 -> EOP2; J/K/SE1 -> framing abort.
//  EOP2:
//   - J -> IDLE with end_rc_nrzi=1, pkt_ok=1.
//   - SE0/K/SE1 -> framing abort.
//  Aborts (abort=1, state -> IDLE, shift reg cleared, bit_count held):
//   - 100 disable: rx_en=0 while busy.
//   - 010 framing: SE1 in DATA, or bad EOP as above.
//   - 001 stuff: run would reach 8 (7 identical levels legal, 8th illegal).
//   - 011 babble: J/K sampled in DATA when bit_count==MAX_BITS.
//  Priority, same sample: rst > disable > framing > stuff > babble > normal.
//  Exclusivity: abort, end_rc_nrzi and start_rc_nrzi are never high together.
//  Back-to-back: after end or abort, the next SYNC is searched from the next cycle.
//  rst asserted mid-packet: return to reset state next cycle; no abort or end pulse.
//  bit_count saturates at MAX_BITS; never wraps.
// TESTING
//  1 Clean packet: KJKJKJKK, 8 alternating J/K, SE0,SE0,J.
//    -> start_rc_nrzi 1 cycle after last K; end_rc_nrzi+pkt_ok 1 cycle after J;
//       bit_count=8; err_code=000.
//  2 Stuff error: SYNC then K held.
//    -> abort on cycle after 6th body K (run=8); err_code=001; busy=0.
//  3 Babble, MAX_BITS=16: SYNC + 17 alternating symbols.
//    -> abort after 17th; err_code=011; bit_count=16.
//  4 Bad EOP: SYNC, 4 bits, SE0, K -> abort; err_code=010.
//    Also SE1 mid-body -> err_code=010.
//  5 rx_en drop mid-DATA -> abort next cycle, err_code=100.
//    SYNC with rc_nrzi_wait=0 -> no start pulse; busy stays 0.
//  6 rst pulse mid-DATA -> all outputs 0, no pulses.
//    Immediate new SYNC after reset release -> start_rc_nrzi as in test 1.

Source files
------------

// File: rtl/usb_rx_sequencer.sv
// usb_rx_sequencer: SYNC/EOP framing controller driving the USB full-speed NRZI decoder and unstuffer
module usb_rx_sequencer #(
  parameter int MAX_BITS = 1100,
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dp,
  input  logic             dm,
  input  logic             rx_en,
  input  logic             rc_nrzi_wait,
  output logic             start_rc_nrzi,
  output logic             end_rc_nrzi,
  output logic             abort,
  output logic             pkt_ok,
  output logic [2:0]       err_code,
  output logic             busy,
  output logic [CNT_W-1:0] bit_count
);
  typedef enum logic [1:0] {IDLE, DATA, EOP1, EOP2} state_t;
  state_t state, state_n;
  logic [7:0] sh, sh_n, sh_shift;
  logic [3:0] run, run_n, run_inc;
  logic last, last_n, start_n, end_n, abort_n;
  logic [2:0] err_n;
  logic [CNT_W-1:0] cnt_n;
  logic jk, se0, se1, sym_j, lvl;
  assign jk = dp ^ dm;
  assign se0 = ~dp & ~dm;
  assign se1 = dp & dm;
  assign sym_j = dp & ~dm;
  assign lvl = dm;
  assign sh_shift = {sh[6:0], lvl};
  assign run_inc = (lvl == last) ? run + 4'd1 : 4'd1;
  assign busy = state != IDLE;
  // Next-state, counters and pulse decisions for the current line sample; K is stored as 1
  always_comb begin
    state_n = state;
    sh_n = '0;
    run_n = run;
    last_n = last;
    cnt_n = bit_count;
    err_n = err_code;
    start_n = 1'b0;
    end_n = 1'b0;
    abort_n = 1'b0;
    if (state == IDLE) begin
      sh_n = jk ? sh_shift : '0;
      if (jk && sh_shift == 8'b10101011 && rx_en && rc_nrzi_wait) begin
        state_n = DATA;
        start_n = 1'b1;
        cnt_n = '0;
        run_n = 4'd2;
        last_n = 1'b1;
        err_n = 3'b000;
        sh_n = '0;
      end
    end else if (!rx_en) begin
      abort_n = 1'b1;
      err_n = 3'b100;
      state_n = IDLE;
    end else if (state == DATA) begin
      if (se1) begin
        abort_n = 1'b1;
        err_n = 3'b010;
        state_n = IDLE;
      end else if (se0) begin
        state_n = EOP1;
      end else if (run_inc == 4'd8) begin
        abort_n = 1'b1;
        err_n = 3'b001;
        state_n = IDLE;
      end else if (bit_count == CNT_W'(MAX_BITS)) begin
        abort_n = 1'b1;
        err_n = 3'b011;
        state_n = IDLE;
      end else begin
        cnt_n = bit_count + 1'b1;
        run_n = run_inc;
        last_n = lvl;
      end
    end else if (state == EOP1) begin
      state_n = se0 ? EOP2 : IDLE;
      abort_n = ~se0;
      err_n = se0 ? err_code : 3'b010;
    end else begin
      state_n = IDLE;
      end_n = sym_j;
      abort_n = ~sym_j;
      err_n = sym_j ? err_code : 3'b010;
    end
  end
  // Register state and all outputs; reset wins over any in-flight pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh <= '0;
      run <= '0;
      last <= 1'b0;
      bit_count <= '0;
      err_code <= '0;
      start_rc_nrzi <= 1'b0;
      end_rc_nrzi <= 1'b0;
      pkt_ok <= 1'b0;
      abort <= 1'b0;
    end else begin
      state <= state_n;
      sh <= sh_n;
      run <= run_n;
      last <= last_n;
      bit_count <= cnt_n;
      err_code <= err_n;
      start_rc_nrzi <= start_n;
      end_rc_nrzi <= end_n;
      pkt_ok <= end_n;
      abort <= abort_n;
    end
  end
endmodule
